// File: rtl/pulso_listo_ncanal.sv
// pulso_listo_ncanal -- multi-channel ready-pulse generator.
//
// Each channel synchronises an asynchronous `listo` level, decodes the edge
// type selected by its `modo` field and turns every accepted edge into a
// pulse that lasts ANCHO_PULSO clk cycles. An edge that arrives while a
// pulse is still running is either dropped and flagged in `perdido`
// (REDISPARO = 0) or restarts the pulse width (REDISPARO = 1).
//
// Parameters
//   N_CANALES   : number of independent channels (>= 1)
//   SYNC_ETAPAS : synchroniser depth per channel (>= 2)
//   ANCHO_PULSO : output pulse width in clk cycles (>= 1)
//   REDISPARO   : 0 = drop and flag edges during a pulse, 1 = retrigger
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   reset       : asynchronous, active-high reset
//   listo       : [N] asynchronous level inputs
//   modo        : [2N] edge select, field i = bits [2i+1:2i]
//                 00 off, 01 rising, 10 falling, 11 both
//   clr_perdido : [N] synchronous clear of the matching perdido flag
//   pulso_listo : [N] registered output pulses
//   perdido     : [N] sticky dropped-edge flags (set wins over clear)
//   alguno      : combinational OR of pulso_listo

// One channel: synchroniser, edge decode, width counter, loss flag.
module pulso_listo_canal #(
  parameter int SYNC_ETAPAS = 2,
  parameter int ANCHO_PULSO = 1,
  parameter int REDISPARO   = 0,
  parameter int CW          = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       listo,
  input  logic [1:0] modo,
  input  logic       clr_perdido,
  output logic       pulso_listo,
  output logic       perdido
);
  localparam logic            REDISP = (REDISPARO != 0);
  localparam logic [CW-1:0]   CARGA  = CW'(ANCHO_PULSO);

  logic [SYNC_ETAPAS-1:0] sync_q;
  logic                   prev_q;
  logic [CW-1:0]          cnt_q, cnt_dec, cnt_next;
  logic                   s, rise, fall, flanco, libre, acepta, pierde;

  // Edge decode against the previous synchronised sample.
  always_comb begin
    s      = sync_q[SYNC_ETAPAS-1];
    rise   = s & ~prev_q;
    fall   = ~s & prev_q;
    flanco = (modo[0] & rise) | (modo[1] & fall);
  end

  // Counter next-state. An edge landing on the last cycle of a pulse is
  // accepted rather than dropped: the counter would be free next cycle
  // anyway, so back-to-back 1-cycle pulses never register as a loss.
  always_comb begin
    cnt_dec  = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    libre    = (cnt_dec == '0);
    acepta   = flanco & (libre | REDISP);
    pierde   = flanco & ~acepta;
    cnt_next = acepta ? CARGA : cnt_dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      pulso_listo <= 1'b0;
      perdido     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_ETAPAS-2:0], listo};
      prev_q      <= s;
      cnt_q       <= cnt_next;
      pulso_listo <= (cnt_next != '0);
      // A drop in the same cycle as a clear keeps the flag set.
      perdido     <= pierde | (perdido & ~clr_perdido);
    end
  end
endmodule

module pulso_listo_ncanal #(
  parameter int N_CANALES   = 4,
  parameter int SYNC_ETAPAS = 2,
  parameter int ANCHO_PULSO = 1,
  parameter int REDISPARO   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CANALES-1:0]      listo,
  input  logic [N_CANALES-1:0][1:0] modo,
  input  logic [N_CANALES-1:0]      clr_perdido,
  output logic [N_CANALES-1:0]      pulso_listo,
  output logic [N_CANALES-1:0]      perdido,
  output logic                      alguno
);
  localparam int CW = $clog2(ANCHO_PULSO + 1);

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    pulso_listo_canal #(
      .SYNC_ETAPAS(SYNC_ETAPAS),
      .ANCHO_PULSO(ANCHO_PULSO),
      .REDISPARO  (REDISPARO),
      .CW         (CW)
    ) u_canal (
      .clk        (clk),
      .reset      (reset),
      .listo      (listo[i]),
      .modo       (modo[i]),
      .clr_perdido(clr_perdido[i]),
      .pulso_listo(pulso_listo[i]),
      .perdido    (perdido[i])
    );
  end

  assign alguno = |pulso_listo;
endmodule

// File: tb/tb_pulso_listo_ncanal.sv
// Bench for pulso_listo_ncanal. Four instances share clk/reset:
//   ch0        : N=1, W=1, REDISPARO=0
//   ch1        : N=1, W=4, REDISPARO=0
//   ch2        : N=1, W=4, REDISPARO=1
//   ch3..ch6   : N=4, W=2, REDISPARO=0 (channels 0..3)
// Stimulus pushes expected pulses (start cycle, width) and perdido values
// into queues; a negedge monitor measures pulses and pops/compares.
module tb_pulso_listo_ncanal;
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  logic [0:0] listo_1, clr_1, pl_1, pd_1;  logic [1:0] modo_1;
  logic [0:0] listo_d, clr_d, pl_d, pd_d;  logic [1:0] modo_d;
  logic [0:0] listo_r, clr_r, pl_r, pd_r;  logic [1:0] modo_r;
  logic [3:0] listo_n, clr_n, pl_n, pd_n;  logic [7:0] modo_n;
  logic alg_1, alg_d, alg_r, alg_n;

  pulso_listo_ncanal #(.N_CANALES(1), .SYNC_ETAPAS(2), .ANCHO_PULSO(1), .REDISPARO(0)) u_1 (
    .clk(clk), .reset(reset), .listo(listo_1), .modo(modo_1), .clr_perdido(clr_1),
    .pulso_listo(pl_1), .perdido(pd_1), .alguno(alg_1));
  pulso_listo_ncanal #(.N_CANALES(1), .SYNC_ETAPAS(2), .ANCHO_PULSO(4), .REDISPARO(0)) u_d (
    .clk(clk), .reset(reset), .listo(listo_d), .modo(modo_d), .clr_perdido(clr_d),
    .pulso_listo(pl_d), .perdido(pd_d), .alguno(alg_d));
  pulso_listo_ncanal #(.N_CANALES(1), .SYNC_ETAPAS(2), .ANCHO_PULSO(4), .REDISPARO(1)) u_r (
    .clk(clk), .reset(reset), .listo(listo_r), .modo(modo_r), .clr_perdido(clr_r),
    .pulso_listo(pl_r), .perdido(pd_r), .alguno(alg_r));
  pulso_listo_ncanal #(.N_CANALES(4), .SYNC_ETAPAS(2), .ANCHO_PULSO(2), .REDISPARO(0)) u_n (
    .clk(clk), .reset(reset), .listo(listo_n), .modo(modo_n), .clr_perdido(clr_n),
    .pulso_listo(pl_n), .perdido(pd_n), .alguno(alg_n));

  logic [6:0] pl_all, pd_all;
  logic [3:0] alg_all;
  assign pl_all  = {pl_n, pl_r, pl_d, pl_1};
  assign pd_all  = {pd_n, pd_r, pd_d, pd_1};
  assign alg_all = {alg_n, alg_r, alg_d, alg_1};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int st; int w; } ev_t;
  typedef struct { int c; int ch; bit v; } pd_t;
  ev_t exp_q[7][$];
  pd_t pd_q[$];
  bit  exp_alg[4][4096];
  int  n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int ch, input int st, input int w);
    ev_t e;
    e.st = st; e.w = w;
    exp_q[ch].push_back(e);
    for (int c = st; c < st + w; c++)
      if (c < 4096) exp_alg[(ch < 3) ? ch : 3][c] = 1'b1;
  endtask

  task automatic push_pd(input int ch, input int c, input bit v);
    pd_t p;
    p.c = c; p.ch = ch; p.v = v;
    pd_q.push_back(p);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: measures each pulse run and checks it against the queue.
  int run_st[7], run_w[7];
  bit run_on[7];
  initial begin
    ev_t e;
    pd_t p;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 7; ch++) begin
        if (pl_all[ch] === 1'b1) begin
          if (!run_on[ch]) begin run_on[ch] = 1'b1; run_st[ch] = cyc; run_w[ch] = 0; end
          run_w[ch]++;
        end else if (run_on[ch]) begin
          run_on[ch] = 1'b0;
          if (exp_q[ch].size() == 0) begin
            chk($sformatf("unexpected pulse ch%0d start", ch), run_st[ch], -1);
          end else begin
            e = exp_q[ch].pop_front();
            chk($sformatf("pulse start ch%0d", ch), run_st[ch], e.st);
            chk($sformatf("pulse width ch%0d", ch), run_w[ch], e.w);
          end
        end
      end
      for (int d = 0; d < 4; d++)
        if (cyc < 4096 && (exp_alg[d][cyc] || alg_all[d] !== 1'b0))
          chk($sformatf("alguno dut%0d", d), int'(alg_all[d]), int'(exp_alg[d][cyc]));
      while (pd_q.size() > 0 && pd_q[0].c <= cyc) begin
        p = pd_q.pop_front();
        chk($sformatf("perdido ch%0d", p.ch), int'(pd_all[p.ch]), int'(p.v));
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1;
    listo_1 = 1'b1; modo_1 = 2'b01; clr_1 = '0;
    listo_d = '0;   modo_d = 2'b11; clr_d = '0;
    listo_r = '0;   modo_r = 2'b01; clr_r = '0;
    listo_n = '0;   modo_n = 8'b00_11_10_01; clr_n = '0;
    #25;
    chk("reset pulso_listo", int'(pl_all), 0);
    chk("reset perdido", int'(pd_all), 0);
    chk("reset alguno", int'(alg_all), 0);
    tick(2);

    // listo already high at release -> one rising pulse on ch0
    k = cyc; reset = 1'b0; push_ev(0, k + 3, 1);
    tick(20);

    // modo 01: pulses on rises only
    for (int i = 0; i < 2; i++) begin
      listo_1 = 1'b0; tick(50);
      k = cyc; listo_1 = 1'b1; push_ev(0, k + 3, 1); tick(50);
    end
    // modo 10: falls only
    modo_1 = 2'b10;
    k = cyc; listo_1 = 1'b0; push_ev(0, k + 3, 1); tick(50);
    listo_1 = 1'b1; tick(50);
    // modo 11: both
    modo_1 = 2'b11;
    k = cyc; listo_1 = 1'b0; push_ev(0, k + 3, 1); tick(50);
    k = cyc; listo_1 = 1'b1; push_ev(0, k + 3, 1); tick(50);
    // modo 00: nothing, no loss
    modo_1 = 2'b00;
    listo_1 = 1'b0; tick(50);
    listo_1 = 1'b1; tick(50);
    push_pd(0, cyc + 2, 1'b0); tick(5);
    listo_1 = 1'b0; tick(10);

    // back-to-back edges, W=1, modo 11: contiguous 2 cycles, no loss
    modo_1 = 2'b11;
    k = cyc; listo_1 = 1'b1; push_ev(0, k + 3, 2); push_pd(0, k + 8, 1'b0);
    tick(1); listo_1 = 1'b0; tick(15);

    // W=4, REDISPARO=0: fall dropped, perdido set
    k = cyc; listo_d = 1'b1; push_ev(1, k + 3, 4);
    push_pd(1, k + 4, 1'b0); push_pd(1, k + 8, 1'b1);
    tick(2); listo_d = 1'b0; tick(15);
    // clear coinciding with a new drop: flag stays set
    k = cyc; listo_d = 1'b1; push_ev(1, k + 3, 4); push_pd(1, k + 6, 1'b1);
    tick(2); listo_d = 1'b0; tick(2); clr_d = 1'b1; tick(1); clr_d = 1'b0; tick(15);
    // clear alone
    k = cyc; clr_d = 1'b1; push_pd(1, k + 1, 1'b0);
    tick(1); clr_d = 1'b0; tick(10);

    // W=4, REDISPARO=1: rises 2 cycles apart x3 -> one 8-cycle pulse
    k = cyc; push_ev(2, k + 3, 8); push_pd(2, k + 12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      listo_r = 1'b1; tick(1); listo_r = 1'b0; tick(1);
    end
    tick(15);

    // 4 channels, modos 01/10/11/00
    k = cyc; listo_n = 4'b1111; push_ev(3, k + 3, 2); push_ev(5, k + 3, 2); tick(10);
    k = cyc; listo_n = 4'b0000; push_ev(4, k + 3, 2); push_ev(5, k + 3, 2); tick(10);
    k = cyc; listo_n = 4'b0100; push_ev(5, k + 3, 2); push_ev(3, k + 4, 2);
    push_pd(5, k + 6, 1'b1); push_pd(3, k + 6, 1'b0); push_pd(6, k + 6, 1'b0);
    tick(1); listo_n = 4'b0001; tick(1); listo_n = 4'b0000; tick(15);
    k = cyc; clr_n = 4'b0100; push_pd(5, k + 1, 1'b0);
    tick(1); clr_n = 4'b0000; tick(5);

    // async reset in the 2nd cycle of a 4-cycle pulse that already lost an edge
    k = cyc; listo_d = 1'b1; push_ev(1, k + 3, 2);
    tick(1); listo_d = 1'b0; tick(3);
    #5;
    chk("pre-reset pulso ch1", int'(pl_d), 1);
    chk("pre-reset perdido ch1", int'(pd_d), 1);
    reset = 1'b1;
    #1;
    chk("async reset pulso", int'(pl_all), 0);
    chk("async reset perdido", int'(pd_all), 0);
    chk("async reset alguno", int'(alg_all), 0);
    tick(2); reset = 1'b0; tick(15);
    chk("post-release perdido", int'(pd_all), 0);

    for (int ch = 0; ch < 7; ch++)
      chk($sformatf("missing pulses ch%0d", ch), exp_q[ch].size(), 0);
    chk("pending perdido checks", pd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
